// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback / syscall stage.
// WB_SYSCALL_TIMEOUT_EN (optional) makes SYS_TIMEOUT_VAL the value returned on a timed-out syscall.
package wb_pkg;

  localparam int MAX_XLEN  = 64;
  localparam int MAX_ARGS  = 16;
  localparam int ARG_BUS_W = MAX_XLEN * MAX_ARGS;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} wb_state_t;

  typedef enum logic [1:0] {SRC_ALU, SRC_MEM, SRC_SYS} wb_src_t;

  localparam logic [MAX_XLEN-1:0] SYS_TIMEOUT_VAL = '1;

  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_csr;
    logic       is_atomic;
    logic       is_ecall;
    logic [4:0] rd;
    logic       en_rd;
  } decoded_inst_t;

  // Callers widen their packed argument bus to ARG_BUS_W and truncate the result to their XLEN.
  function automatic logic [MAX_XLEN-1:0] arg_slice(input logic [ARG_BUS_W-1:0] args,
                                                    input int idx, input int xlen);
    logic [ARG_BUS_W-1:0] shifted;
    logic [MAX_XLEN-1:0]  mask;
    shifted = args >> (idx * xlen);
    mask    = {MAX_XLEN{1'b1}} >> (MAX_XLEN - xlen);
    return shifted[MAX_XLEN-1:0] & mask;
  endfunction

endpackage

// File: rtl/wb_syscall_stage_if.sv
// Request/response bus between the writeback stage (master) and the external syscall service (slave).
// With WB_SYSCALL_TIMEOUT_EN defined the bus also carries the sc_timeout pulse.
interface wb_syscall_stage_if #(
  parameter int XLEN  = 64,
  parameter int NARGS = 8
);

  logic                        sc_req_valid;
  logic                        sc_req_ready;
  logic [XLEN-1:0]             sc_num;
  logic [(NARGS-1)*XLEN-1:0]   sc_args;
  logic                        sc_resp_valid;
  logic [XLEN-1:0]             sc_resp_data;
`ifdef WB_SYSCALL_TIMEOUT_EN
  logic                        sc_timeout;

  modport master (output sc_req_valid, sc_num, sc_args, sc_timeout,
                  input  sc_req_ready, sc_resp_valid, sc_resp_data);
  modport slave  (input  sc_req_valid, sc_num, sc_args, sc_timeout,
                  output sc_req_ready, sc_resp_valid, sc_resp_data);
`else
  modport master (output sc_req_valid, sc_num, sc_args,
                  input  sc_req_ready, sc_resp_valid, sc_resp_data);
  modport slave  (input  sc_req_valid, sc_num, sc_args,
                  output sc_req_ready, sc_resp_valid, sc_resp_data);
`endif

endinterface

// File: rtl/wb_syscall_fsm.sv
// Syscall handshake sequencer: IDLE -> REQ -> WAIT -> DONE, captures the service's return value.
// WB_SYSCALL_TIMEOUT_EN adds a WAIT-state timeout that returns all-ones and pulses sc_timeout.
module wb_syscall_fsm
  import wb_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int NARGS          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NARGS*XLEN-1:0]   args,
  wb_syscall_stage_if.master      sc,
  output logic                    stall,
  output logic                    done,
  output logic [XLEN-1:0]         ret_val
);

  if (XLEN > MAX_XLEN || NARGS > MAX_ARGS || NARGS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_syscall_fsm: unsupported parameterisation");
  end

  wb_state_t                 state;
  logic                      req_valid_q;
  logic [XLEN-1:0]           num_q;
  logic [(NARGS-1)*XLEN-1:0] args_q;

`ifdef WB_SYSCALL_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]          tmo_cnt;
  logic                      timeout_q;
`endif

  // Request fields are latched on entry to REQ so they cannot move while sc_req_valid is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_valid_q <= 1'b0;
      num_q       <= '0;
      args_q      <= '0;
      ret_val     <= '0;
`ifdef WB_SYSCALL_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef WB_SYSCALL_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state       <= REQ;
            req_valid_q <= 1'b1;
            num_q       <= XLEN'(arg_slice(ARG_BUS_W'(args), NARGS - 1, XLEN));
            args_q      <= args[(NARGS-1)*XLEN-1:0];
          end
        end
        REQ: begin
          if (sc.sc_req_ready) begin
            state       <= WAIT;
            req_valid_q <= 1'b0;
`ifdef WB_SYSCALL_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        WAIT: begin
          if (sc.sc_resp_valid) begin
            ret_val <= sc.sc_resp_data;
            state   <= DONE;
          end
`ifdef WB_SYSCALL_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            ret_val   <= XLEN'(SYS_TIMEOUT_VAL);
            timeout_q <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign sc.sc_req_valid = req_valid_q;
  assign sc.sc_num       = num_q;
  assign sc.sc_args      = args_q;
`ifdef WB_SYSCALL_TIMEOUT_EN
  assign sc.sc_timeout   = timeout_q;
`endif

  assign stall = (state == REQ) || (state == WAIT) || ((state == IDLE) && start);
  assign done  = (state == DONE);

  resp_only_in_wait: assert property (@(posedge clk) disable iff (reset)
                                      sc.sc_resp_valid |-> (state == WAIT));

endmodule

// File: rtl/wb_syscall_stage.sv
// Writeback stage: result select, register-file write gating, retire counting, syscall handshake.
// Optional macro WB_SYSCALL_TIMEOUT_EN enables the syscall response timeout (sc_timeout on the bus).
module wb_syscall_stage
  import wb_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int NARGS          = 8,
  parameter int CNT_W          = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  decoded_inst_t         inst,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       mem_result,
  input  logic [NARGS*XLEN-1:0] args,
  output logic [XLEN-1:0]       result,
  output logic [4:0]            rd,
  output logic                  en_rd,
  output logic                  stall,
  wb_syscall_stage_if.master    sc,
  output logic                  retire,
  output logic [CNT_W-1:0]      instret
);

  logic            live;
  logic            sys_done;
  logic            commit;
  logic [XLEN-1:0] sys_ret;
  wb_src_t         src;

  // Masking in_valid with reset keeps stall/write/retire quiet while reset is held.
  assign live = in_valid & ~reset;

  wb_syscall_fsm #(
    .XLEN           (XLEN),
    .NARGS          (NARGS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk     (clk),
    .reset   (reset),
    .start   (live & inst.is_ecall),
    .args    (args),
    .sc      (sc),
    .stall   (stall),
    .done    (sys_done),
    .ret_val (sys_ret)
  );

  always_comb begin
    src = SRC_ALU;
    if (inst.is_ecall)
      src = SRC_SYS;
    else if (inst.is_load || inst.is_store || inst.is_csr || inst.is_atomic)
      src = SRC_MEM;
  end

  always_comb begin
    result = alu_result;
    case (src)
      SRC_MEM: result = mem_result;
      SRC_SYS: result = sys_ret;
      default: result = alu_result;
    endcase
  end

  // An ecall only commits in its DONE cycle; everything else commits the cycle it arrives.
  assign commit = inst.is_ecall ? sys_done : 1'b1;
  assign rd     = inst.rd;
  assign en_rd  = live & inst.en_rd & (inst.rd != 5'd0) & commit;
  assign retire = sys_done | (live & ~inst.is_ecall);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      instret <= '0;
    else if (retire)
      instret <= instret + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_syscall_stage.sv
// Directed self-checking bench for wb_syscall_stage.
// Build with WB_SYSCALL_TIMEOUT_EN defined to also exercise the timeout path (TIMEOUT_CYCLES = 8).
module tb_wb_syscall_stage;
  import wb_pkg::*;

  localparam int XLEN  = 64;
  localparam int NARGS = 8;
  localparam int CNT_W = 64;
  localparam int TMO   = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  decoded_inst_t         inst;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       mem_result;
  logic [NARGS*XLEN-1:0] args;
  logic [XLEN-1:0]       result;
  logic [4:0]            rd;
  logic                  en_rd;
  logic                  stall;
  logic                  retire;
  logic [CNT_W-1:0]      instret;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_syscall_stage_if #(.XLEN(XLEN), .NARGS(NARGS)) sc_bus ();

  wb_syscall_stage #(
    .XLEN           (XLEN),
    .NARGS          (NARGS),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .inst       (inst),
    .alu_result (alu_result),
    .mem_result (mem_result),
    .args       (args),
    .result     (result),
    .rd         (rd),
    .en_rd      (en_rd),
    .stall      (stall),
    .sc         (sc_bus),
    .retire     (retire),
    .instret    (instret)
  );

  function automatic decoded_inst_t mk(input bit ld, input bit st, input bit csr, input bit amo,
                                       input bit ec, input logic [4:0] r, input bit en);
    decoded_inst_t d;
    d.is_load   = ld;
    d.is_store  = st;
    d.is_csr    = csr;
    d.is_atomic = amo;
    d.is_ecall  = ec;
    d.rd        = r;
    d.en_rd     = en;
    return d;
  endfunction

  function automatic logic [NARGS*XLEN-1:0] mk_args(input logic [XLEN-1:0] a0,
                                                    input logic [XLEN-1:0] a7);
    logic [NARGS*XLEN-1:0] v;
    for (int i = 0; i < NARGS; i++) v[i*XLEN +: XLEN] = 64'hA000 + 64'(i);
    v[0 +: XLEN]               = a0;
    v[(NARGS-1)*XLEN +: XLEN]  = a7;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid                = 1'b0;
    inst                    = mk(0, 0, 0, 0, 0, 5'd0, 0);
    alu_result              = '0;
    mem_result              = '0;
    args                    = '0;
    sc_bus.sc_req_ready     = 1'b0;
    sc_bus.sc_resp_valid    = 1'b0;
    sc_bus.sc_resp_data     = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #2;
    total_cnt++;
    if (result !== 64'd0) $display("[TB] FAIL reset_result: got %h expected 0", result);
    else pass_cnt++;
    total_cnt++;
    if ({stall, en_rd, retire} !== 3'b000)
      $display("[TB] FAIL reset_ctrl: got %b expected 000", {stall, en_rd, retire});
    else pass_cnt++;
    total_cnt++;
    if (sc_bus.sc_req_valid !== 1'b0 || sc_bus.sc_num !== 64'd0)
      $display("[TB] FAIL reset_req: got valid=%b num=%h expected 0/0",
               sc_bus.sc_req_valid, sc_bus.sc_num);
    else pass_cnt++;
    total_cnt++;
    if (instret !== 64'd0) $display("[TB] FAIL reset_instret: got %0d expected 0", instret);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_alu;
    in_valid   = 1'b1;
    inst       = mk(0, 0, 0, 0, 0, 5'd5, 1);
    alu_result = 64'h2A;
    mem_result = 64'h55;
    #1;
    total_cnt++;
    if ({en_rd, retire, stall} !== 3'b110 || result !== 64'h2A || rd !== 5'd5)
      $display("[TB] FAIL alu_add: got en_rd=%b retire=%b stall=%b result=%h rd=%0d expected 1/1/0/2a/5",
               en_rd, retire, stall, result, rd);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (instret !== 64'd1) $display("[TB] FAIL alu_instret: got %0d expected 1", instret);
    else pass_cnt++;
    total_cnt++;
    if ({en_rd, retire, stall} !== 3'b000)
      $display("[TB] FAIL bubble_ctrl: got %b expected 000", {en_rd, retire, stall});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (instret !== 64'd1) $display("[TB] FAIL bubble_instret: got %0d expected 1", instret);
    else pass_cnt++;
  endtask

  task automatic test_mem_select;
    logic [XLEN-1:0] exp_mem;
    for (int i = 0; i < 4; i++) begin
      in_valid   = 1'b1;
      inst       = mk(i == 0, i == 1, i == 2, i == 3, 0, (i == 0) ? 5'd0 : 5'd3, 1);
      exp_mem    = 64'hDEAD + 64'(i * 256);
      mem_result = exp_mem;
      alu_result = 64'h1234;
      #1;
      total_cnt++;
      if (result !== exp_mem || en_rd !== (i != 0) || retire !== 1'b1 || stall !== 1'b0)
        $display("[TB] FAIL mem_select_%0d: got result=%h en_rd=%b retire=%b stall=%b expected %h/%b/1/0",
                 i, result, en_rd, retire, stall, exp_mem, (i != 0));
      else pass_cnt++;
      tick();
    end
    in_valid = 1'b0;
    total_cnt++;
    if (instret !== 64'd5) $display("[TB] FAIL mem_instret: got %0d expected 5", instret);
    else pass_cnt++;
  endtask

  task automatic test_ecall;
    int retires;
    logic [3:0] exp_v;
    retires = 0;
    args    = mk_args(64'd1, 64'd64);
    for (int c = 0; c < 8; c++) begin
      in_valid                = (c <= 5);
      inst                    = mk(0, 0, 0, 0, 1, 5'd10, 1);
      alu_result              = 64'h999;
      mem_result              = 64'h888;
      sc_bus.sc_req_ready     = (c == 2);
      sc_bus.sc_resp_valid    = (c == 4);
      sc_bus.sc_resp_data     = (c == 4) ? 64'h10 : 64'hBAD;
      #1;
      exp_v = {c <= 4, (c == 1) || (c == 2), c == 5, c == 5};
      total_cnt++;
      if ({stall, sc_bus.sc_req_valid, retire, en_rd} !== exp_v)
        $display("[TB] FAIL ecall_cycle%0d: got stall/req/retire/en_rd=%b expected %b",
                 c, {stall, sc_bus.sc_req_valid, retire, en_rd}, exp_v);
      else pass_cnt++;
      if (c == 1) begin
        total_cnt++;
        if (sc_bus.sc_num !== 64'd64 || sc_bus.sc_args[63:0] !== 64'd1)
          $display("[TB] FAIL ecall_fields: got num=%0d a0=%0d expected 64/1",
                   sc_bus.sc_num, sc_bus.sc_args[63:0]);
        else pass_cnt++;
      end
      if (c == 5) begin
        total_cnt++;
        if (result !== 64'h10) $display("[TB] FAIL ecall_result: got %h expected 10", result);
        else pass_cnt++;
      end
      if (retire === 1'b1) retires++;
      tick();
    end
    idle_inputs();
    total_cnt++;
    if (retires != 1 || instret !== 64'd6)
      $display("[TB] FAIL ecall_retire: got retires=%0d instret=%0d expected 1/6", retires, instret);
    else pass_cnt++;
  endtask

  task automatic test_ready_low;
    logic [3:0] exp_v;
    logic [NARGS*XLEN-1:0] exp_args;
    exp_args = mk_args(64'h77, 64'd93);
    args     = exp_args;
    for (int c = 0; c < 12; c++) begin
      in_valid                = (c <= 10);
      inst                    = mk(0, 0, 0, 0, 1, 5'd11, 1);
      sc_bus.sc_req_ready     = (c == 7);
      sc_bus.sc_resp_valid    = (c == 9);
      sc_bus.sc_resp_data     = (c == 9) ? 64'hABC : 64'h0;
      #1;
      exp_v = {c <= 9, (c >= 1) && (c <= 7), c == 10, c == 10};
      total_cnt++;
      if ({stall, sc_bus.sc_req_valid, retire, en_rd} !== exp_v)
        $display("[TB] FAIL ready_low_cycle%0d: got stall/req/retire/en_rd=%b expected %b",
                 c, {stall, sc_bus.sc_req_valid, retire, en_rd}, exp_v);
      else pass_cnt++;
      if (c >= 1 && c <= 7) begin
        total_cnt++;
        if ({sc_bus.sc_num, sc_bus.sc_args} !== exp_args)
          $display("[TB] FAIL ready_low_args%0d: got num=%0d a0=%h expected 93/77",
                   c, sc_bus.sc_num, sc_bus.sc_args[63:0]);
        else pass_cnt++;
      end
      if (c == 10) begin
        total_cnt++;
        if (result !== 64'hABC) $display("[TB] FAIL ready_low_result: got %h expected abc", result);
        else pass_cnt++;
      end
      tick();
    end
    idle_inputs();
    total_cnt++;
    if (instret !== 64'd7) $display("[TB] FAIL ready_low_instret: got %0d expected 7", instret);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_v;
    for (int c = 0; c < 9; c++) begin
      in_valid                = (c <= 7);
      inst                    = (c <= 3) ? mk(0, 0, 0, 0, 1, 5'd12, 1) : mk(0, 0, 0, 0, 1, 5'd13, 1);
      args                    = (c <= 3) ? mk_args(64'h5, 64'd1) : mk_args(64'h6, 64'd2);
      sc_bus.sc_req_ready     = (c == 1) || (c == 5);
      sc_bus.sc_resp_valid    = (c == 2) || (c == 6);
      sc_bus.sc_resp_data     = (c == 2) ? 64'h111 : 64'h222;
      #1;
      exp_v = {(c <= 2) || ((c >= 4) && (c <= 6)), (c == 1) || (c == 5),
               (c == 3) || (c == 7), (c == 3) || (c == 7)};
      total_cnt++;
      if ({stall, sc_bus.sc_req_valid, retire, en_rd} !== exp_v)
        $display("[TB] FAIL b2b_cycle%0d: got stall/req/retire/en_rd=%b expected %b",
                 c, {stall, sc_bus.sc_req_valid, retire, en_rd}, exp_v);
      else pass_cnt++;
      if (c == 3) begin
        total_cnt++;
        if (result !== 64'h111 || rd !== 5'd12)
          $display("[TB] FAIL b2b_first: got result=%h rd=%0d expected 111/12", result, rd);
        else pass_cnt++;
      end
      if (c == 5) begin
        total_cnt++;
        if (sc_bus.sc_num !== 64'd2) $display("[TB] FAIL b2b_num: got %0d expected 2", sc_bus.sc_num);
        else pass_cnt++;
      end
      if (c == 7) begin
        total_cnt++;
        if (result !== 64'h222 || rd !== 5'd13)
          $display("[TB] FAIL b2b_second: got result=%h rd=%0d expected 222/13", result, rd);
        else pass_cnt++;
      end
      tick();
    end
    idle_inputs();
    total_cnt++;
    if (instret !== 64'd9) $display("[TB] FAIL b2b_instret: got %0d expected 9", instret);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    args     = mk_args(64'h3, 64'd7);
    in_valid = 1'b1;
    inst     = mk(0, 0, 0, 0, 1, 5'd14, 1);
    tick();
    sc_bus.sc_req_ready = 1'b1;
    #1;
    total_cnt++;
    if (sc_bus.sc_req_valid !== 1'b1) $display("[TB] FAIL rst_mid_req: got %b expected 1", sc_bus.sc_req_valid);
    else pass_cnt++;
    tick();
    sc_bus.sc_req_ready = 1'b0;
    reset               = 1'b1;
    #1;
    total_cnt++;
    if ({stall, sc_bus.sc_req_valid, retire, en_rd} !== 4'b0000 || result !== 64'd0 || instret !== 64'd0)
      $display("[TB] FAIL rst_mid_async: got ctrl=%b result=%h instret=%0d expected 0000/0/0",
               {stall, sc_bus.sc_req_valid, retire, en_rd}, result, instret);
    else pass_cnt++;
    tick();
    in_valid             = 1'b0;
    sc_bus.sc_resp_valid = 1'b1;
    sc_bus.sc_resp_data  = 64'h5555;
    tick();
    sc_bus.sc_resp_valid = 1'b0;
    reset                = 1'b0;
    tick();
    total_cnt++;
    if ({stall, sc_bus.sc_req_valid, retire, en_rd} !== 4'b0000 || instret !== 64'd0)
      $display("[TB] FAIL rst_mid_idle: got ctrl=%b instret=%0d expected 0000/0",
               {stall, sc_bus.sc_req_valid, retire, en_rd}, instret);
    else pass_cnt++;
    in_valid = 1'b1;
    #1;
    total_cnt++;
    if (result !== 64'd0 || stall !== 1'b1)
      $display("[TB] FAIL rst_mid_capture: got result=%h stall=%b expected 0/1", result, stall);
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
    inst       = mk(0, 0, 0, 0, 0, 5'd1, 1);
    alu_result = 64'h77;
    in_valid   = 1'b1;
    #1;
    total_cnt++;
    if (sc_bus.sc_req_valid !== 1'b0 || retire !== 1'b1)
      $display("[TB] FAIL rst_mid_fresh: got req=%b retire=%b expected 0/1", sc_bus.sc_req_valid, retire);
    else pass_cnt++;
    tick();
    idle_inputs();
    total_cnt++;
    if (instret !== 64'd1) $display("[TB] FAIL rst_mid_instret: got %0d expected 1", instret);
    else pass_cnt++;
  endtask

`ifdef WB_SYSCALL_TIMEOUT_EN
  task automatic test_timeout;
    logic [4:0] exp_v;
    int pulses;
    pulses = 0;
    args   = mk_args(64'h9, 64'd101);
    for (int c = 0; c < 12; c++) begin
      in_valid             = (c <= 10);
      inst                 = mk(0, 0, 0, 0, 1, 5'd15, 1);
      sc_bus.sc_req_ready  = (c == 1);
      sc_bus.sc_resp_valid = 1'b0;
      #1;
      exp_v = {c <= 9, c == 1, c == 10, c == 10, c == 10};
      total_cnt++;
      if ({stall, sc_bus.sc_req_valid, retire, en_rd, sc_bus.sc_timeout} !== exp_v)
        $display("[TB] FAIL timeout_cycle%0d: got stall/req/retire/en_rd/tmo=%b expected %b",
                 c, {stall, sc_bus.sc_req_valid, retire, en_rd, sc_bus.sc_timeout}, exp_v);
      else pass_cnt++;
      if (c == 10) begin
        total_cnt++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFF) $display("[TB] FAIL timeout_result: got %h expected all-ones", result);
        else pass_cnt++;
      end
      if (sc_bus.sc_timeout === 1'b1) pulses++;
      tick();
    end
    idle_inputs();
    total_cnt++;
    if (pulses != 1 || instret !== 64'd2)
      $display("[TB] FAIL timeout_pulse: got pulses=%0d instret=%0d expected 1/2", pulses, instret);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_mem_select();
    test_ecall();
    test_ready_low();
    test_back_to_back();
    test_reset_mid();
`ifdef WB_SYSCALL_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

endmodule
